// File: rtl/watch_fsm_multi_if.sv
// Button inputs and display/status outputs of the watch mode controller.
interface watch_fsm_multi_if;
    logic       btn_mode;
    logic       btn_start;
    logic       btn_change;
    logic [3:0] s_unidade_fsm;
    logic [3:0] s_dezena_fsm;
    logic [3:0] m_unidade_fsm;
    logic [3:0] m_dezena_fsm;
    logic [3:0] h_unidade_fsm;
    logic [3:0] h_dezena_fsm;
    logic [1:0] mode;
    logic [1:0] cfg_field;
    logic       is_config;
    logic       alarm_en;
    logic       alarm_ring;

    modport slave (
        input  btn_mode, btn_start, btn_change,
        output s_unidade_fsm, s_dezena_fsm, m_unidade_fsm, m_dezena_fsm,
               h_unidade_fsm, h_dezena_fsm, mode, cfg_field, is_config,
               alarm_en, alarm_ring
    );

    modport master (
        output btn_mode, btn_start, btn_change,
        input  s_unidade_fsm, s_dezena_fsm, m_unidade_fsm, m_dezena_fsm,
               h_unidade_fsm, h_dezena_fsm, mode, cfg_field, is_config,
               alarm_en, alarm_ring
    );
endinterface

// File: rtl/watch_fsm_multi.sv
// Watch mode controller: BCD clock, stopwatch, alarm with auto-timeout and
// clock/alarm configuration, driving six BCD display digits.
module watch_fsm_multi #(
    parameter int TICK_DIV   = 50000000,
    parameter int HOURS_MAX  = 24,
    parameter int ALARM_SECS = 30
) (
    input  logic               clk,
    input  logic               rst,
    watch_fsm_multi_if.slave   bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(ALARM_SECS + 1);

    typedef enum logic [1:0] {M_CLOCK = 2'd0, M_SW = 2'd1, M_ACFG = 2'd2, M_CCFG = 2'd3} mode_e;
    typedef struct packed {
        logic [3:0] t;
        logic [3:0] u;
    } bcd2_t;

    localparam bcd2_t LAST59 = '{t: 4'd5, u: 4'd9};
    localparam bcd2_t LAST99 = '{t: 4'd9, u: 4'd9};
    localparam bcd2_t HLAST  = '{t: 4'((HOURS_MAX - 1) / 10), u: 4'((HOURS_MAX - 1) % 10)};

    // Two-digit BCD increment that wraps to 00 after reaching 'last'.
    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t last);
        bcd2_t r;
        if (v == last) begin
            r = '0;
        end else if (v.u == 4'd9) begin
            r.t = v.t + 4'd1;
            r.u = 4'd0;
        end else begin
            r.t = v.t;
            r.u = v.u + 4'd1;
        end
        return r;
    endfunction

    mode_e          mode_q, mode_d;
    logic [1:0]     cfg_q, cfg_d;
    logic           aen_q, aen_d;
    logic           ring_q, ring_d;
    logic           run_q, run_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic [PW-1:0]  presc_q, presc_d;
    bcd2_t          ch_q, cm_q, cs_q, ch_d, cm_d, cs_d;
    bcd2_t          wh_q, wm_q, ws_q, wh_d, wm_d, ws_d;
    bcd2_t          ah_q, am_q, ah_d, am_d;
    logic [2:0]     prev_q;
    logic [2:0]     btn, click;
    logic           tick, trig;

    assign btn   = {bus.btn_mode, bus.btn_start, bus.btn_change};
    assign click = btn & ~prev_q;
    assign tick  = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        mode_d  = mode_q;
        cfg_d   = cfg_q;
        aen_d   = aen_q;
        ring_d  = ring_q;
        run_d   = run_q;
        rcnt_d  = rcnt_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        ch_d = ch_q; cm_d = cm_q; cs_d = cs_q;
        wh_d = wh_q; wm_d = wm_q; ws_d = ws_q;
        ah_d = ah_q; am_d = am_q;
        trig = 1'b0;

        if (tick && mode_q != M_CCFG) begin
            cs_d = bcd_inc(cs_q, LAST59);
            if (cs_q == LAST59) begin
                cm_d = bcd_inc(cm_q, LAST59);
                if (cm_q == LAST59) ch_d = bcd_inc(ch_q, HLAST);
            end
            // Only a time advance can fire the alarm; edits never do.
            trig = aen_q && (cs_d == '0) && (cm_d == am_q) && (ch_d == ah_q);
        end

        if (tick && run_q) begin
            ws_d = bcd_inc(ws_q, LAST59);
            if (ws_q == LAST59) begin
                wm_d = bcd_inc(wm_q, LAST59);
                if (wm_q == LAST59) wh_d = bcd_inc(wh_q, LAST99);
            end
        end

        if (ring_q && tick) begin
            rcnt_d = rcnt_q - RW'(1);
            if (rcnt_q == RW'(1)) ring_d = 1'b0;
        end

        if (ring_q && (click != 3'b000)) begin
            ring_d = 1'b0;
        end else if (click[2]) begin
            if (mode_q == M_CCFG) presc_d = '0;
            mode_d = mode_e'(mode_q + 2'd1);
            cfg_d  = 2'd0;
        end else if (click[1]) begin
            case (mode_q)
                M_CLOCK: aen_d = ~aen_q;
                M_SW:    run_d = ~run_q;
                M_ACFG:  cfg_d = (cfg_q == 2'd0) ? 2'd1 : 2'd0;
                default: cfg_d = (cfg_q == 2'd2) ? 2'd0 : cfg_q + 2'd1;
            endcase
        end else if (click[0]) begin
            case (mode_q)
                M_SW: if (!run_q) begin
                    wh_d = '0; wm_d = '0; ws_d = '0;
                end
                M_ACFG: begin
                    if (cfg_q == 2'd0) ah_d = bcd_inc(ah_q, HLAST);
                    else               am_d = bcd_inc(am_q, LAST59);
                end
                M_CCFG: begin
                    if (cfg_q == 2'd0)      ch_d = bcd_inc(ch_q, HLAST);
                    else if (cfg_q == 2'd1) cm_d = bcd_inc(cm_q, LAST59);
                    else                    cs_d = bcd_inc(cs_q, LAST59);
                end
                default: ;
            endcase
        end

        if (trig) begin
            ring_d = 1'b1;
            rcnt_d = RW'(ALARM_SECS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= M_CLOCK;
            cfg_q   <= 2'd0;
            aen_q   <= 1'b0;
            ring_q  <= 1'b0;
            run_q   <= 1'b0;
            rcnt_q  <= '0;
            presc_q <= '0;
            ch_q <= '0; cm_q <= '0; cs_q <= '0;
            wh_q <= '0; wm_q <= '0; ws_q <= '0;
            ah_q <= '0; am_q <= '0;
            prev_q  <= 3'b000;
        end else begin
            mode_q  <= mode_d;
            cfg_q   <= cfg_d;
            aen_q   <= aen_d;
            ring_q  <= ring_d;
            run_q   <= run_d;
            rcnt_q  <= rcnt_d;
            presc_q <= presc_d;
            ch_q <= ch_d; cm_q <= cm_d; cs_q <= cs_d;
            wh_q <= wh_d; wm_q <= wm_d; ws_q <= ws_d;
            ah_q <= ah_d; am_q <= am_d;
            prev_q  <= btn;
        end
    end

    bcd2_t dh, dm, ds;
    always_comb begin
        dh = ch_q; dm = cm_q; ds = cs_q;
        case (mode_q)
            M_SW:    begin dh = wh_q; dm = wm_q; ds = ws_q; end
            M_ACFG:  begin dh = ah_q; dm = am_q; ds = '0;   end
            default: ;
        endcase
    end

    assign bus.h_dezena_fsm  = dh.t;
    assign bus.h_unidade_fsm = dh.u;
    assign bus.m_dezena_fsm  = dm.t;
    assign bus.m_unidade_fsm = dm.u;
    assign bus.s_dezena_fsm  = ds.t;
    assign bus.s_unidade_fsm = ds.u;
    assign bus.mode          = mode_q;
    assign bus.cfg_field     = cfg_q;
    assign bus.is_config     = mode_q[1];
    assign bus.alarm_en      = aen_q;
    assign bus.alarm_ring    = ring_q;
endmodule

// File: tb/tb_watch_fsm_multi.sv
// Scoreboard bench: 24h and 12h instances share button stimulus; an
// integer-seconds reference model predicts every output each cycle.
module tb_watch_fsm_multi;
    localparam int TD = 4;
    localparam int AS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    watch_fsm_multi_if b24();
    watch_fsm_multi_if b12();

    watch_fsm_multi #(.TICK_DIV(TD), .HOURS_MAX(24), .ALARM_SECS(AS)) u24 (.clk(clk), .rst(rst), .bus(b24.slave));
    watch_fsm_multi #(.TICK_DIV(TD), .HOURS_MAX(12), .ALARM_SECS(AS)) u12 (.clk(clk), .rst(rst), .bus(b12.slave));

    typedef struct { int v [2][11]; } exp_t;
    exp_t sb[$];
    string fname [11] = '{"h_dez", "h_uni", "m_dez", "m_uni", "s_dez", "s_uni",
                          "mode", "cfg_field", "is_config", "alarm_en", "alarm_ring"};

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state (time kept as plain seconds).
    int hmax [2] = '{24, 12};
    int mode [2], cfg [2], aen [2], ring [2], rcnt [2], presc [2];
    int csec [2], sws [2], run [2], ah [2], am [2];
    bit pb [3];

    task automatic model_step(input bit r, input bit bm, input bit bs, input bit bc);
        bit cm, cs, cc, tick, trig, ring_old;
        int h, m, s;
        cm = bm & !pb[0]; cs = bs & !pb[1]; cc = bc & !pb[2];
        pb[0] = r ? 1'b0 : bm; pb[1] = r ? 1'b0 : bs; pb[2] = r ? 1'b0 : bc;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mode[k] = 0; cfg[k] = 0; aen[k] = 0; ring[k] = 0; rcnt[k] = 0; presc[k] = 0;
                csec[k] = 0; sws[k] = 0; run[k] = 0; ah[k] = 0; am[k] = 0;
            end else begin
                ring_old = ring[k] != 0;
                tick = presc[k] == TD - 1;
                presc[k] = tick ? 0 : presc[k] + 1;
                trig = 0;
                if (tick && mode[k] != 3) begin
                    csec[k] = (csec[k] + 1) % (hmax[k] * 3600);
                    trig = aen[k] != 0 && csec[k] == ah[k] * 3600 + am[k] * 60;
                end
                if (tick && run[k] != 0) sws[k] = (sws[k] + 1) % 360000;
                if (tick && ring_old) begin
                    rcnt[k]--;
                    if (rcnt[k] == 0) ring[k] = 0;
                end
                if (ring_old && (cm | cs | cc)) begin
                    ring[k] = 0;
                end else if (cm) begin
                    if (mode[k] == 3) presc[k] = 0;
                    mode[k] = (mode[k] + 1) % 4;
                    cfg[k] = 0;
                end else if (cs) begin
                    case (mode[k])
                        0: aen[k] = 1 - aen[k];
                        1: run[k] = 1 - run[k];
                        2: cfg[k] = 1 - cfg[k];
                        default: cfg[k] = (cfg[k] + 1) % 3;
                    endcase
                end else if (cc) begin
                    h = csec[k] / 3600; m = (csec[k] / 60) % 60; s = csec[k] % 60;
                    case (mode[k])
                        1: if (run[k] == 0) sws[k] = 0;
                        2: if (cfg[k] == 0) ah[k] = (ah[k] + 1) % hmax[k];
                           else am[k] = (am[k] + 1) % 60;
                        3: begin
                            if (cfg[k] == 0) h = (h + 1) % hmax[k];
                            else if (cfg[k] == 1) m = (m + 1) % 60;
                            else s = (s + 1) % 60;
                            csec[k] = h * 3600 + m * 60 + s;
                        end
                        default: ;
                    endcase
                end
                if (trig) begin
                    ring[k] = 1;
                    rcnt[k] = AS;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int h, m, s;
        for (int k = 0; k < 2; k++) begin
            h = csec[k] / 3600; m = (csec[k] / 60) % 60; s = csec[k] % 60;
            if (mode[k] == 1) begin
                h = sws[k] / 3600; m = (sws[k] / 60) % 60; s = sws[k] % 60;
            end else if (mode[k] == 2) begin
                h = ah[k]; m = am[k]; s = 0;
            end
            e.v[k][0] = h / 10; e.v[k][1] = h % 10;
            e.v[k][2] = m / 10; e.v[k][3] = m % 10;
            e.v[k][4] = s / 10; e.v[k][5] = s % 10;
            e.v[k][6] = mode[k]; e.v[k][7] = cfg[k];
            e.v[k][8] = (mode[k] >= 2) ? 1 : 0;
            e.v[k][9] = aen[k]; e.v[k][10] = ring[k];
        end
        return e;
    endfunction

    task automatic cyc(input bit r, input bit bm, input bit bs, input bit bc);
        @(negedge clk);
        rst = r;
        b24.btn_mode = bm; b24.btn_start = bs; b24.btn_change = bc;
        b12.btn_mode = bm; b12.btn_start = bs; b12.btn_change = bc;
        model_step(r, bm, bs, bc);
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic click(input int b);
        cyc(0, b == 0, b == 1, b == 2);
        cyc(0, 0, 0, 0);
    endtask

    task automatic goto_mode(input int md);
        for (int i = 0; i < 8 && mode[0] != md; i++) click(0);
    endtask

    // Expects CLOCK_CFG with hours field selected; leaves hours selected.
    task automatic set_clock(input int h, input int m, input int s);
        repeat ((h - csec[0] / 3600 + 24) % 24) click(2);
        click(1);
        repeat ((m - (csec[0] / 60) % 60 + 60) % 60) click(2);
        click(1);
        repeat ((s - csec[0] % 60 + 60) % 60) click(2);
        click(1);
    endtask

    // Monitor: pops one expectation per cycle and compares every output.
    initial begin
        exp_t e;
        int a [11];
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 2; k++) begin
                    if (k == 0)
                        a = '{int'(b24.h_dezena_fsm), int'(b24.h_unidade_fsm), int'(b24.m_dezena_fsm),
                              int'(b24.m_unidade_fsm), int'(b24.s_dezena_fsm), int'(b24.s_unidade_fsm),
                              int'(b24.mode), int'(b24.cfg_field), int'(b24.is_config),
                              int'(b24.alarm_en), int'(b24.alarm_ring)};
                    else
                        a = '{int'(b12.h_dezena_fsm), int'(b12.h_unidade_fsm), int'(b12.m_dezena_fsm),
                              int'(b12.m_unidade_fsm), int'(b12.s_dezena_fsm), int'(b12.s_unidade_fsm),
                              int'(b12.mode), int'(b12.cfg_field), int'(b12.is_config),
                              int'(b12.alarm_en), int'(b12.alarm_ring)};
                    for (int f = 0; f < 11; f++) begin
                        n_chk++;
                        if (a[f] != e.v[k][f]) begin
                            n_fail++;
                            $display("FAIL %s[h%0d] t=%0t: got %0d expected %0d",
                                     fname[f], hmax[k], $time, a[f], e.v[k][f]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        b24.btn_mode = 0; b24.btn_start = 0; b24.btn_change = 0;
        b12.btn_mode = 0; b12.btn_start = 0; b12.btn_change = 0;
        pb[0] = 0; pb[1] = 0; pb[2] = 0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        idle(2);

        // Day wrap: 24h reaches 23:59:58, 12h reaches 11:59:58 (hours edit wraps at 11).
        goto_mode(3);
        set_clock(23, 59, 58);
        goto_mode(0);
        idle(12);

        // Stopwatch run/stop/clear, clear ignored while running.
        goto_mode(1);
        click(1); idle(12); click(1);
        click(2);
        click(1); idle(4); click(2); idle(8); click(1);

        // Alarm 00:01, timeout without dismissal.
        goto_mode(2);
        click(1); click(2);
        goto_mode(3);
        set_clock(0, 0, 59);
        goto_mode(0);
        click(1);
        idle(24);

        // Alarm again, dismissed with change.
        goto_mode(3);
        set_clock(0, 0, 59);
        goto_mode(0);
        idle(6);
        click(2);
        idle(2);

        // Simultaneous mode+start; held start toggles once.
        goto_mode(1);
        cyc(0, 1, 1, 0); cyc(0, 0, 0, 0);
        goto_mode(1);
        repeat (10) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        idle(8);

        // Reset mid-ring with stopwatch running.
        goto_mode(3);
        set_clock(0, 0, 59);
        goto_mode(0);
        idle(6);
        cyc(1, 0, 0, 0);
        idle(3);

        // Reset in CLOCK_CFG with seconds field selected.
        goto_mode(3);
        click(1); click(1);
        cyc(1, 0, 0, 0);
        idle(2);

        // Random button activity with rare resets.
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);

        idle(1);
        @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
